// File: rtl/sar_oversample_avg.sv
// Conversion sequencer and oversampling averager for a SAR binary-search FSM.
// Issues start pulses, sums 2**LOG2N results, publishes the truncated mean, and times out stalled conversions.
module sar_oversample_avg #(
  parameter int NOB       = 7,
  parameter int LOG2N     = 2,
  parameter int TO_CYCLES = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           clr,
  input  logic           valid_in,
  input  logic [NOB-1:0] result_in,
  output logic           go,
  output logic [NOB-1:0] avg_out,
  output logic           avg_valid,
  output logic           busy,
  output logic           err
);

  localparam int N     = 1 << LOG2N;
  localparam int ACC_W = NOB + LOG2N;
  localparam int CNT_W = (LOG2N > 1) ? LOG2N : 1;
  localparam int TMR_W = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TO_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [TMR_W-1:0] r_tmr;
  logic             r_vin_d;
  logic             r_go;
  logic             r_avg_valid;
  logic             r_busy;
  logic             r_err;
  logic [NOB-1:0]   r_avg;

  logic             w_edge;
  logic             w_timeout;
  logic [ACC_W-1:0] w_sum;

  assign w_edge    = valid_in & ~r_vin_d;
  assign w_sum     = r_acc + ACC_W'(result_in);
  assign w_timeout = (r_state == S_WAIT) && !w_edge && (r_tmr == TMR_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_tmr       <= '0;
      r_vin_d     <= 1'b0;
      r_go        <= 1'b0;
      r_avg_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_avg       <= '0;
    end else begin
      r_vin_d     <= valid_in;
      r_go        <= 1'b0;
      r_avg_valid <= 1'b0;

      if (w_timeout) begin
        r_err <= 1'b1;
      end else if (clr) begin
        r_err <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (en) begin
            r_state <= S_START;
            r_go    <= 1'b1;
            r_busy  <= 1'b1;
          end
        end

        S_START: begin
          r_tmr   <= '0;
          r_state <= S_WAIT;
        end

        S_WAIT: begin
          if (w_edge) begin
            r_acc <= w_sum;
            if (r_cnt == CNT_LAST) begin
              // Mean is registered on the way into DONE so it and its strobe appear in the DONE cycle.
              r_avg       <= NOB'(w_sum >> LOG2N);
              r_avg_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_cnt   <= r_cnt + CNT_W'(1);
              r_go    <= 1'b1;
              r_state <= S_START;
            end
          end else if (r_tmr == TMR_LAST) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_tmr <= r_tmr + TMR_W'(1);
          end
        end

        S_DONE: begin
          r_acc <= '0;
          r_cnt <= '0;
          if (en) begin
            r_go    <= 1'b1;
            r_state <= S_START;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign go        = r_go;
  assign avg_out   = r_avg;
  assign avg_valid = r_avg_valid;
  assign busy      = r_busy;
  assign err       = r_err;

endmodule

// File: tb/tb_sar_oversample_avg.sv
// Directed bench for sar_oversample_avg: a behavioural SAR responder drives two instances (LOG2N=2 and LOG2N=0).
module tb_sar_oversample_avg;

  logic       clk;
  logic       rst_n;
  logic       en_a;
  logic       en_b;
  logic       clr;
  logic       valid_in;
  logic [6:0] result_in;

  logic       go_a, av_a, busy_a, err_a;
  logic [6:0] avg_a;
  logic       go_b, av_b, busy_b, err_b;
  logic [6:0] avg_b;

  sar_oversample_avg #(.NOB(7), .LOG2N(2), .TO_CYCLES(64)) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en_a),
    .clr       (clr),
    .valid_in  (valid_in),
    .result_in (result_in),
    .go        (go_a),
    .avg_out   (avg_a),
    .avg_valid (av_a),
    .busy      (busy_a),
    .err       (err_a)
  );

  sar_oversample_avg #(.NOB(7), .LOG2N(0), .TO_CYCLES(64)) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en_b),
    .clr       (clr),
    .valid_in  (valid_in),
    .result_in (result_in),
    .go        (go_b),
    .avg_out   (avg_b),
    .avg_valid (av_b),
    .busy      (busy_b),
    .err       (err_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Event monitor: counts pulses and timestamps them in negedge cycles.
  int cyc = 0;
  int go_cnt_a = 0;
  int av_cnt_a = 0;
  int go_cyc_a = 0;
  int go_cnt_b = 0;
  int av_cnt_b = 0;
  int hist_b[$];

  always @(negedge clk) begin
    cyc++;
    if (go_a === 1'b1) begin
      go_cnt_a++;
      go_cyc_a = cyc;
    end
    if (av_a === 1'b1) av_cnt_a++;
    if (go_b === 1'b1) go_cnt_b++;
    if (av_b === 1'b1) begin
      av_cnt_b++;
      hist_b.push_back(int'(avg_b));
    end
  end

  // SAR responder: answers each go after sar_lat cycles, pulse or level style.
  logic [6:0] res_q[$];
  logic       sel_b = 1'b0;
  logic       stall = 1'b0;
  logic       level = 1'b0;
  int         sar_lat = 4;
  int         glitch_req = 0;
  int         glitch_done = 0;
  int         m_pending = 0;
  int         m_lat = 0;
  int         m_drop = 0;
  logic       m_go;

  initial begin
    valid_in  = 1'b0;
    result_in = '0;
    forever begin
      @(negedge clk);
      m_go = sel_b ? go_b : go_a;
      if (!rst_n) begin
        m_pending = 0;
        m_drop    = 0;
        valid_in  = 1'b0;
      end else begin
        if (m_drop > 0) begin
          m_drop--;
          if (m_drop == 0) valid_in = 1'b0;
        end else if (!level && valid_in) begin
          valid_in = 1'b0;
        end
        if (m_go === 1'b1) begin
          m_pending = stall ? 0 : 1;
          m_lat     = sar_lat;
          if (level && valid_in) m_drop = 2;
        end else if (m_pending != 0) begin
          if (m_lat > 0) begin
            m_lat--;
          end else begin
            valid_in  = 1'b1;
            result_in = (res_q.size() > 0) ? res_q.pop_front() : 7'd0;
            m_pending = 0;
          end
        end else if (glitch_req != glitch_done && !valid_in) begin
          glitch_done++;
          valid_in  = 1'b1;
          result_in = 7'd99;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  function automatic int get_cnt(input int which);
    case (which)
      0:       return av_cnt_a;
      1:       return go_cnt_a;
      2:       return av_cnt_b;
      default: return int'(err_a);
    endcase
  endfunction

  task automatic wait_cnt(input int which, input int target, input string tag);
    for (int i = 0; i < 400; i++) begin
      if (get_cnt(which) >= target) break;
      step(1);
    end
    check_eq(tag, get_cnt(which), target);
  endtask

  task automatic push4(input int a, input int b, input int c, input int d);
    res_q.push_back(7'(a));
    res_q.push_back(7'(b));
    res_q.push_back(7'(c));
    res_q.push_back(7'(d));
  endtask

  int g_cyc;
  int base;
  int expb[4] = '{5, 127, 0, 64};

  initial begin
    rst_n = 1'b0;
    en_a  = 1'b1;
    en_b  = 1'b0;
    clr   = 1'b0;
    step(3);
    check_eq("rst_go", go_a, 0);
    check_eq("rst_avg_valid", av_a, 0);
    check_eq("rst_avg", avg_a, 0);
    check_eq("rst_busy", busy_a, 0);
    check_eq("rst_err", err_a, 0);

    // Batch 1: 10,11,12,13 -> 46>>2 = 11
    push4(10, 11, 12, 13);
    rst_n = 1'b1;
    step(1);
    check_eq("first_go", go_a, 1);
    check_eq("first_busy", busy_a, 1);
    wait_cnt(0, 1, "b1_done");
    check_eq("b1_go_count", go_cnt_a, 4);
    check_eq("b1_strobe", av_a, 1);
    check_eq("b1_avg", avg_a, 11);

    // Batch 2: full scale; batch 3: zeros with en dropped after the 2nd sample
    push4(127, 127, 127, 127);
    push4(0, 0, 0, 0);
    step(1);
    check_eq("b2b_go", go_a, 1);
    check_eq("strobe_one_cycle", av_a, 0);
    check_eq("avg_held", avg_a, 11);
    wait_cnt(0, 2, "b2_done");
    check_eq("b2_avg_fullscale", avg_a, 127);
    wait_cnt(1, 11, "b3_third_go");
    en_a = 1'b0;
    wait_cnt(0, 3, "b3_done");
    check_eq("b3_avg_zero", avg_a, 0);
    check_eq("b3_go_count", go_cnt_a, 12);
    step(20);
    check_eq("b3_no_more_go", go_cnt_a, 12);
    check_eq("b3_idle_busy", busy_a, 0);
    check_eq("b3_one_strobe", av_cnt_a, 3);

    // Level-style SAR: 20,30,40,50 -> 140>>2 = 35
    level = 1'b1;
    push4(20, 30, 40, 50);
    en_a = 1'b1;
    wait_cnt(0, 4, "lvl_done");
    en_a = 1'b0;
    check_eq("lvl_avg", avg_a, 35);
    check_eq("lvl_go_count", go_cnt_a, 16);
    level = 1'b0;
    step(3);
    glitch_req++;
    step(8);
    check_eq("glitch_go", go_cnt_a, 16);
    check_eq("glitch_strobe", av_cnt_a, 4);
    check_eq("glitch_busy", busy_a, 0);
    check_eq("glitch_avg", avg_a, 35);

    // Timeout: no valid after go
    stall = 1'b1;
    base  = go_cnt_a;
    en_a  = 1'b1;
    wait_cnt(1, base + 1, "to_go");
    g_cyc = go_cyc_a;
    en_a  = 1'b0;
    wait_cnt(3, 1, "to_err");
    check_eq("to_latency", cyc - g_cyc, 65);
    check_eq("to_busy", busy_a, 0);
    check_eq("to_no_strobe", av_cnt_a, 4);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check_eq("clr_err", err_a, 0);

    // Timeout coinciding with clr: set wins
    base = go_cnt_a;
    en_a = 1'b1;
    wait_cnt(1, base + 1, "to2_go");
    g_cyc = go_cyc_a;
    en_a  = 1'b0;
    for (int i = 0; i < 200 && cyc < g_cyc + 64; i++) step(1);
    check_eq("to2_reach", cyc, g_cyc + 64);
    check_eq("to2_pre_err", err_a, 0);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check_eq("to2_set_wins", err_a, 1);
    check_eq("to2_busy", busy_a, 0);
    stall = 1'b0;

    // Reset in WAIT after 3 samples, then a clean batch 1,2,3,6 -> 12>>2 = 3
    push4(100, 100, 100, 100);
    base = go_cnt_a;
    en_a = 1'b1;
    wait_cnt(1, base + 4, "rst_mid_go");
    step(2);
    check_eq("rst_mid_busy_pre", busy_a, 1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_avg", avg_a, 0);
    check_eq("rst_mid_busy", busy_a, 0);
    check_eq("rst_mid_err", err_a, 0);
    check_eq("rst_mid_go", go_a, 0);
    check_eq("rst_mid_strobe", av_a, 0);
    res_q.delete();
    step(2);
    push4(1, 2, 3, 6);
    rst_n = 1'b1;
    wait_cnt(0, 5, "post_rst_done");
    en_a = 1'b0;
    check_eq("post_rst_avg", avg_a, 3);

    // LOG2N=0 instance: pass-through with a strobe per conversion
    step(5);
    sel_b = 1'b1;
    push4(expb[0], expb[1], expb[2], expb[3]);
    en_b = 1'b1;
    wait_cnt(2, 4, "pt_done");
    en_b = 1'b0;
    step(10);
    check_eq("pt_strobes", hist_b.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("pt_avg%0d", i), (i < hist_b.size()) ? hist_b[i] : -1, expb[i]);
    end
    check_eq("pt_go_count", go_cnt_b, 4);
    check_eq("pt_a_untouched", av_cnt_a, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
